// File: rtl/id_fetch_buffer.sv
// -----------------------------------------------------------------------------
// id_fetch_buffer
//   Circular {pc,inst} FIFO between instruction fetch and decode, with a
//   load-use interlock that holds the head entry for a programmable number of
//   bubble cycles. The interlock fires when the EX-stage load writes a register
//   that the head instruction reads as rs or rt.
//
// Ports
//   clk              sole clock; all state updates on posedge
//   rst              synchronous active-high reset
//   flush            discard all buffered entries and any pending bubbles
//   in_valid/ready   fetch-side handshake; in_pc/in_inst carry the entry
//   out_valid/ready  decode-side handshake; out_pc/out_inst show the head
//   ex_load_valid    EX stage holds a load
//   ex_load_waddr    destination register of that load
//   stallreq_for_id  load-use interlock active this cycle
//   count            number of occupied entries
// -----------------------------------------------------------------------------
module id_fetch_buffer #(
    parameter int DEPTH            = 4,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     ex_load_valid,
    input  logic [4:0]               ex_load_waddr,
    output logic                     stallreq_for_id,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Bubble counter is reloaded with one less than the total stall length,
    // because the detect cycle itself already stalls.
    localparam logic [2:0] BUB_LOAD = 3'(LOAD_USE_BUBBLES - 1);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [2:0]    bub_cnt;

    logic not_empty;
    logic hazard;
    logic push;
    logic pop;

    // NOTE: every signal driven here gets a value on every path (defaults
    // first), so no latch can be inferred.
    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q < CW'(DEPTH));
        out_pc    = 32'h0;
        out_inst  = 32'h0;
        if (not_empty) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end

        // Detection is suppressed while a bubble sequence is in progress, so
        // one hazard yields exactly LOAD_USE_BUBBLES stall cycles.
        hazard = not_empty && (bub_cnt == 3'd0) && ex_load_valid &&
                 (ex_load_waddr != 5'd0) &&
                 ((ex_load_waddr == out_inst[25:21]) ||
                  (ex_load_waddr == out_inst[20:16]));

        stallreq_for_id = hazard || (bub_cnt != 3'd0);
        out_valid       = not_empty && !stallreq_for_id;

        push = in_valid && in_ready && !flush;
        pop  = out_valid && out_ready && !flush;
    end

    assign count = count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            bub_cnt <= 3'd0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            bub_cnt <= 3'd0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (hazard)                bub_cnt <= BUB_LOAD;
            else if (bub_cnt != 3'd0)  bub_cnt <= bub_cnt - 3'd1;
        end
    end

    // NOTE: storage is not reset; entries are only visible through count,
    // which is, so a reset-free RAM-style array is sufficient.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

endmodule

// File: tb/tb_id_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_id_fetch_buffer
//   Two instances share all inputs: dut_a with one load-use bubble, dut_b with
//   three. A queue-based model predicts every output each cycle; directed
//   sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_id_fetch_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  count;
        logic        in_ready;
        logic        out_valid;
        logic        stall;
        logic        hazard;
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_inst = 32'h0;
    logic        out_ready = 1'b0;
    logic        ex_load_valid = 1'b0;
    logic [4:0]  ex_load_waddr = 5'd0;

    logic        in_ready_a, out_valid_a, stall_a;
    logic [31:0] out_pc_a, out_inst_a;
    logic [2:0]  count_a;
    logic        in_ready_b, out_valid_b, stall_b;
    logic [31:0] out_pc_b, out_inst_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_fetch_buffer #(.DEPTH(DEPTH), .LOAD_USE_BUBBLES(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a), .out_inst(out_inst_a),
        .ex_load_valid(ex_load_valid), .ex_load_waddr(ex_load_waddr),
        .stallreq_for_id(stall_a), .count(count_a)
    );

    id_fetch_buffer #(.DEPTH(DEPTH), .LOAD_USE_BUBBLES(3)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_inst(out_inst_b),
        .ex_load_valid(ex_load_valid), .ex_load_waddr(ex_load_waddr),
        .stallreq_for_id(stall_b), .count(count_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance: a queue of {pc,inst} and the cycle number at which the
    // current stall window ends (stall while cyc < stall_end).
    logic [63:0] mq [2][$];
    int          stall_end [2];
    int          cyc = 0;
    bit          chk_en = 1'b0;

    function automatic int bubbles(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic exp_t model_exp(int i);
        exp_t        e;
        int          n;
        logic [63:0] h;
        logic [4:0]  rs, rt;
        n = mq[i].size();
        h = (n > 0) ? mq[i][0] : 64'h0;
        e.count     = 3'(n);
        e.in_ready  = (n < DEPTH);
        e.pc        = h[63:32];
        e.inst      = h[31:0];
        rs          = e.inst[25:21];
        rt          = e.inst[20:16];
        e.hazard    = (n > 0) && (cyc >= stall_end[i]) && ex_load_valid &&
                      (ex_load_waddr != 5'd0) &&
                      (ex_load_waddr == rs || ex_load_waddr == rt);
        e.stall     = e.hazard || (cyc < stall_end[i]);
        e.out_valid = (n > 0) && !e.stall;
        return e;
    endfunction

    initial begin
        stall_end[0] = 0;
        stall_end[1] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                e = model_exp(i);
                if (rst || flush) begin
                    mq[i].delete();
                    stall_end[i] = 0;
                end else begin
                    if (e.hazard) stall_end[i] = cyc + bubbles(i);
                    if (e.out_valid && out_ready) void'(mq[i].pop_front());
                    if (in_valid && e.in_ready) mq[i].push_back({in_pc, in_inst});
                end
            end
            if (rst) chk_en = 1'b1;
            cyc++;
        end
    end

    task automatic cmp(input string tag, input exp_t e, input logic [2:0] c,
                       input logic ir, input logic ov, input logic st,
                       input logic [31:0] pc, input logic [31:0] inst);
        check({tag, ".count"},     64'(c),  64'(e.count));
        check({tag, ".in_ready"},  64'(ir), 64'(e.in_ready));
        check({tag, ".out_valid"}, 64'(ov), 64'(e.out_valid));
        check({tag, ".stall"},     64'(st), 64'(e.stall));
        check({tag, ".out_pc"},    64'(pc), 64'(e.pc));
        check({tag, ".out_inst"},  64'(inst), 64'(e.inst));
    endtask

    // Compare on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("a", model_exp(0), count_a, in_ready_a, out_valid_a, stall_a, out_pc_a, out_inst_a);
            cmp("b", model_exp(1), count_b, in_ready_b, out_valid_b, stall_b, out_pc_b, out_inst_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDU_RS4 = 32'h0085_1021;  // addu $2,$4,$5
    localparam logic [31:0] ADDU_RS0 = 32'h0000_1021;  // addu $2,$0,$0
    localparam logic [31:0] PLAIN    = 32'h2400_0000;

    initial begin
        int n_a, n_b;
        bit got_b;
        logic [31:0] iss_b;
        logic [31:0] pcr;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst.count",     64'(count_a), 64'd0);
        check("rst.in_ready",  64'(in_ready_a), 64'd1);
        check("rst.out_valid", 64'(out_valid_a), 64'd0);
        check("rst.out_pc",    64'(out_pc_a), 64'd0);
        check("rst.stall",     64'(stall_b), 64'd0);

        // Fill to full, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_pc   = 32'h100 + 32'(4 * k);
            in_inst = PLAIN;
            step();
        end
        in_valid = 1'b0;
        check("fill.count",    64'(count_a), 64'd4);
        check("fill.in_ready", 64'(in_ready_a), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain.out_pc",    64'(out_pc_a), 64'(32'h100 + 32'(4 * k)));
            check("drain.out_valid", 64'(out_valid_a), 64'd1);
            step();
        end
        check("drain.count", 64'(count_a), 64'd0);

        // Full: push and pop same cycle -> pop only, push accepted next cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_pc = 32'h100 + 32'(4 * k);
            step();
        end
        in_pc     = 32'h200;
        out_ready = 1'b1;
        #1;
        check("full.in_ready", 64'(in_ready_a), 64'd0);
        step();
        out_ready = 1'b0;
        check("full.pop_only", 64'(count_a), 64'd3);
        check("full.ready_again", 64'(in_ready_a), 64'd1);
        step();
        check("full.push_next", 64'(count_a), 64'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        out_ready = 1'b0;

        // Load-use hazard: 1 bubble on dut_a, 3 on dut_b
        in_valid = 1'b1;
        in_pc    = 32'h300;
        in_inst  = ADDU_RS4;
        step();
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        ex_load_valid = 1'b1;
        ex_load_waddr = 5'd4;
        #1;
        n_a = 0; n_b = 0; got_b = 1'b0; iss_b = 32'h0;
        for (int k = 0; k < 6; k++) begin
            if (stall_a) n_a++;
            if (stall_b) n_b++;
            if (out_valid_b && !got_b) begin
                got_b = 1'b1;
                iss_b = out_inst_b;
            end
            step();
            ex_load_valid = 1'b0;
            #1;
        end
        check("haz.stall_cycles_1", 64'(n_a), 64'd1);
        check("haz.stall_cycles_3", 64'(n_b), 64'd3);
        check("haz.head_kept", 64'(iss_b), 64'(ADDU_RS4));

        // Load to $0 never interlocks
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h380;
        in_inst   = ADDU_RS0;
        step();
        in_valid      = 1'b0;
        ex_load_valid = 1'b1;
        ex_load_waddr = 5'd0;
        #1;
        check("zero.out_valid", 64'(out_valid_a), 64'd1);
        check("zero.stall",     64'(stall_a), 64'd0);
        step();
        ex_load_valid = 1'b0;
        out_ready     = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush with count=3 and bubble active, concurrent push dropped
        in_valid = 1'b1;
        in_inst  = ADDU_RS4;
        for (int k = 0; k < 3; k++) begin
            in_pc = 32'h400 + 32'(4 * k);
            step();
        end
        in_valid      = 1'b0;
        ex_load_valid = 1'b1;
        ex_load_waddr = 5'd4;
        step();
        ex_load_valid = 1'b0;
        flush         = 1'b1;
        in_valid      = 1'b1;
        in_pc         = 32'h500;
        #1;
        check("flush.pre_count", 64'(count_b), 64'd3);
        check("flush.pre_bubble", 64'(stall_b), 64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush.count",     64'(count_b), 64'd0);
        check("flush.out_valid", 64'(out_valid_b), 64'd0);
        check("flush.stall",     64'(stall_b), 64'd0);

        // Reset with two entries
        in_valid = 1'b1;
        in_inst  = PLAIN;
        for (int k = 0; k < 2; k++) begin
            in_pc = 32'h600 + 32'(4 * k);
            step();
        end
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst2.count",    64'(count_a), 64'd0);
        check("rst2.in_ready", 64'(in_ready_a), 64'd1);
        check("rst2.out_pc",   64'(out_pc_a), 64'd0);

        // Wrap-around: 10 push/pop pairs through a 4-entry ring
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h700;
        step();
        for (int k = 1; k <= 10; k++) begin
            in_pc = 32'h700 + 32'(4 * k);
            check("wrap.out_pc", 64'(out_pc_a), 64'(32'h700 + 32'(4 * (k - 1))));
            check("wrap.count",  64'(count_a), 64'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Randomised traffic, checked by the model every cycle
        pcr = 32'h1000;
        for (int k = 0; k < 400; k++) begin
            in_valid      = 1'($urandom_range(0, 1));
            out_ready     = 1'($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            rst           = ($urandom_range(0, 79) == 0);
            ex_load_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       ex_load_waddr = 5'd0;
                1:       ex_load_waddr = 5'd4;
                2:       ex_load_waddr = 5'd5;
                default: ex_load_waddr = 5'd9;
            endcase
            case ($urandom_range(0, 2))
                0:       in_inst = ADDU_RS4;
                1:       in_inst = ADDU_RS0;
                default: in_inst = $urandom();
            endcase
            in_pc = pcr;
            pcr   = pcr + 32'd4;
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; ex_load_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
